// File: rtl/matrix_scan_decoder.sv
// Decodes a multiplexed 4x4 LED scan (row/column lines + slow scan clock) back into a frame bitmap.
// Latency: strobe 3 clk_in after scan_clk_in falls; frame_out/frame_valid registered on the closing strobe.
// Backpressure: none; pure monitor, frames are published unconditionally and must be taken on frame_valid.
module matrix_scan_decoder #(
    parameter int ROW    = 4,
    parameter int COLUMN = 4,
    parameter int PIXELS = ROW * COLUMN,
    parameter int WINDOW = 16,
    parameter int SLOT_W = $clog2(WINDOW)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              scan_clk_in,
    input  logic [COLUMN-1:0] data_x_in,
    input  logic [ROW-1:0]    data_y_in,
    output logic [PIXELS-1:0] frame_out,
    output logic              frame_valid,
    output logic              frame_changed,
    output logic [7:0]        glitch_count,
    output logic [SLOT_W-1:0] slot_index
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic              scan_s1, scan_s2, scan_s3;
    logic [COLUMN-1:0] x_s1, x_s2;
    logic [ROW-1:0]    y_s1, y_s2;
    logic [PIXELS-1:0] acc;

    logic              strobe;
    logic              x_one, y_one, x_multi, y_multi;
    logic              slot_lit, slot_glitch;
    logic [PIXELS-1:0] lit_bits;
    logic [PIXELS-1:0] acc_next;

    // Two-flop synchronizers for all scan inputs, plus a third scan flop for edge detection
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scan_s1 <= 1'b0;
            scan_s2 <= 1'b0;
            scan_s3 <= 1'b0;
            x_s1    <= '0;
            x_s2    <= '0;
            y_s1    <= '0;
            y_s2    <= '0;
        end else begin
            scan_s1 <= scan_clk_in;
            scan_s2 <= scan_s1;
            scan_s3 <= scan_s2;
            x_s1    <= data_x_in;
            x_s2    <= x_s1;
            y_s1    <= data_y_in;
            y_s2    <= y_s1;
        end
    end

    // Classify the synchronized lines; the lit pixel is the outer product of the one-hot x and y
    always_comb begin
        strobe      = (state == RUN) && scan_s3 && !scan_s2;
        x_one       = (x_s2 != '0) && ((x_s2 & (x_s2 - 1'b1)) == '0);
        y_one       = (y_s2 != '0) && ((y_s2 & (y_s2 - 1'b1)) == '0);
        x_multi     = (x_s2 != '0) && !x_one;
        y_multi     = (y_s2 != '0) && !y_one;
        slot_glitch = x_multi || y_multi;
        slot_lit    = x_one && y_one;
        lit_bits    = '0;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COLUMN; c++) begin
                lit_bits[r*COLUMN + c] = slot_lit && y_s2[r] && x_s2[c];
            end
        end
        acc_next = acc | lit_bits;
    end

    // Scan FSM: wait for a real high level after reset, then accumulate and publish per window
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            acc           <= '0;
            slot_index    <= '0;
            glitch_count  <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_s2) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (strobe) begin
                        if (slot_glitch && glitch_count != 8'hFF) begin
                            glitch_count <= glitch_count + 8'd1;
                        end
                        if (slot_index == SLOT_W'(WINDOW - 1)) begin
                            frame_out     <= acc_next;
                            frame_valid   <= 1'b1;
                            frame_changed <= (acc_next != frame_out);
                            acc           <= '0;
                            slot_index    <= '0;
                        end else begin
                            acc        <= acc_next;
                            slot_index <= slot_index + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Randomized bench for matrix_scan_decoder against a slot-level frame model.
// Latency: publish expected 3 clk_in after the closing scan_clk_in fall.
// Backpressure: none; every frame_valid pulse is matched against the model queue.
module tb_matrix_scan_decoder;

    localparam int ROW    = 4;
    localparam int COLUMN = 4;
    localparam int PIXELS = 16;
    localparam int WINDOW = 16;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              scan_clk_in;
    logic [COLUMN-1:0] data_x_in;
    logic [ROW-1:0]    data_y_in;
    logic [PIXELS-1:0] frame_out;
    logic              frame_valid;
    logic              frame_changed;
    logic [7:0]        glitch_count;
    logic [3:0]        slot_index;

    matrix_scan_decoder #(
        .ROW(ROW), .COLUMN(COLUMN), .PIXELS(PIXELS), .WINDOW(WINDOW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .scan_clk_in   (scan_clk_in),
        .data_x_in     (data_x_in),
        .data_y_in     (data_y_in),
        .frame_out     (frame_out),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .glitch_count  (glitch_count),
        .slot_index    (slot_index)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is the OR of lit pixels over WINDOW slots
    typedef struct {
        logic [15:0] frame;
        logic        changed;
        int          glitches;
    } pub_t;

    pub_t        expq[$];
    logic [15:0] m_acc    = '0;
    logic [15:0] m_prev   = '0;
    int          m_slot   = 0;
    int          m_glitch = 0;
    int          cyc      = 0;
    int          last_fall = 0;
    logic        prev_valid = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int bit_pos(input logic [3:0] v);
        int p = 0;
        for (int i = 0; i < 4; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic model_slot(input logic [3:0] x, input logic [3:0] y);
        int cx = $countones(x);
        int cy = $countones(y);
        logic [15:0] one = 16'd1;
        pub_t p;
        if (cx > 1 || cy > 1) begin
            if (m_glitch < 255) m_glitch++;
        end else if (cx == 1 && cy == 1) begin
            m_acc = m_acc | (one << (bit_pos(y) * COLUMN + bit_pos(x)));
        end
        m_slot++;
        if (m_slot == WINDOW) begin
            p.frame    = m_acc;
            p.changed  = (m_acc != m_prev);
            p.glitches = m_glitch;
            expq.push_back(p);
            m_prev = m_acc;
            m_acc  = '0;
            m_slot = 0;
        end
    endtask

    // One scan slot: lines change with the rising scan edge, sampled around the falling edge
    task automatic drive_slot(input logic [3:0] x, input logic [3:0] y, input int hi, input int lo);
        data_x_in   = x;
        data_y_in   = y;
        scan_clk_in = 1'b1;
        repeat (hi) @(negedge clk_in);
        scan_clk_in = 1'b0;
        last_fall   = cyc;
        model_slot(x, y);
        repeat (lo) @(negedge clk_in);
    endtask

    // Random slot: mostly lit pixels, some dark, some glitches with both lines nonzero
    task automatic rand_slot(output logic [3:0] x, output logic [3:0] y);
        int k = $urandom_range(0, 9);
        logic [3:0] one = 4'd1;
        if (k < 6) begin
            x = one << $urandom_range(0, 3);
            y = one << $urandom_range(0, 3);
        end else if (k < 8) begin
            x = 4'($urandom_range(0, 15));
            y = 4'd0;
        end else begin
            x = 4'($urandom_range(3, 15)) | 4'b0011;
            y = one << $urandom_range(0, 3);
        end
    endtask

    // Publication monitor
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (frame_valid) begin
                chk("valid_width", {31'd0, prev_valid}, 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    pub_t p;
                    p = expq.pop_front();
                    chk("frame_out", {16'd0, frame_out}, {16'd0, p.frame});
                    chk("frame_changed", {31'd0, frame_changed}, {31'd0, p.changed});
                    chk("glitch_at_pub", {24'd0, glitch_count}, p.glitches);
                    chk("publish_latency", cyc - last_fall, 32'd3);
                end
            end else if (frame_changed) begin
                chk("changed_without_valid", 32'd1, 32'd0);
            end
        end
        prev_valid <= frame_valid;
    end

    logic [3:0] rx, ry;
    logic [3:0] jx[16];
    logic [3:0] jy[16];

    initial begin
        rst_n_in    = 1'b0;
        scan_clk_in = 1'b0;
        data_x_in   = '0;
        data_y_in   = '0;

        // Reset held: inputs toggling must not move any output
        repeat (20) begin
            @(negedge clk_in);
            scan_clk_in = 1'($urandom_range(0, 1));
            data_x_in   = 4'($urandom_range(0, 15));
            data_y_in   = 4'($urandom_range(0, 15));
        end
        @(negedge clk_in);
        chk("rst_frame_out", {16'd0, frame_out}, 32'd0);
        chk("rst_valid", {30'd0, frame_valid, frame_changed}, 32'd0);
        chk("rst_glitch", {24'd0, glitch_count}, 32'd0);
        chk("rst_slot", {28'd0, slot_index}, 32'd0);
        scan_clk_in = 1'b0;
        data_x_in   = '0;
        data_y_in   = '0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("idle_slot", {28'd0, slot_index}, 32'd0);

        // Walking pixel, twice: second window must not flag a change
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 16; s++) drive_slot(4'd1 << (s % 4), 4'd1 << (s / 4), 4, 4);
            chk("walk_frame", {16'd0, frame_out}, 32'h0000FFFF);
        end

        // Sparse frame: corners (0,0) and (3,3)
        for (int s = 0; s < 16; s++) begin
            if (s == 0)       drive_slot(4'b0001, 4'b0001, 4, 4);
            else if (s == 15) drive_slot(4'b1000, 4'b1000, 4, 4);
            else              drive_slot(4'b0000, 4'b0100, 4, 4);
        end
        chk("sparse_frame", {16'd0, frame_out}, 32'h00008001);

        // Single glitch then saturation
        drive_slot(4'b0011, 4'b0001, 4, 4);
        chk("glitch_one", {24'd0, glitch_count}, 32'd1);
        for (int i = 0; i < 300; i++) drive_slot(4'b0011, 4'b0001, 3, 3);
        repeat (4) @(negedge clk_in);
        chk("glitch_sat", {24'd0, glitch_count}, 32'd255);

        // Reset mid-window discards the partial accumulation
        for (int s = 0; s < 7; s++) drive_slot(4'b0001 << (s % 4), 4'b0001, 4, 4);
        repeat (5) @(negedge clk_in);
        chk("queue_before_reset", expq.size(), 32'd0);
        rst_n_in = 1'b0;
        expq.delete();
        m_acc = '0; m_prev = '0; m_slot = 0; m_glitch = 0;
        repeat (3) @(negedge clk_in);
        chk("midrst_glitch", {24'd0, glitch_count}, 32'd0);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        for (int s = 0; s < 16; s++) begin
            if (s == 5) drive_slot(4'b0100, 4'b0010, 4, 4);
            else        drive_slot(4'b0000, 4'b0000, 4, 4);
        end
        chk("midrst_frame", {16'd0, frame_out}, 32'h00000040);

        // Jittered scan clock: same slot pattern each window, same frame every time
        for (int s = 0; s < 16; s++) rand_slot(jx[s], jy[s]);
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < 16; s++)
                drive_slot(jx[s], jy[s], $urandom_range(3, 50), $urandom_range(3, 50));
        end

        // Fully random windows, including a partial tail
        for (int i = 0; i < 16 * 4 + 5; i++) begin
            rand_slot(rx, ry);
            drive_slot(rx, ry, $urandom_range(3, 8), $urandom_range(3, 8));
        end

        repeat (10) @(negedge clk_in);
        chk("pending_frames", expq.size(), 32'd0);
        chk("final_slot", {28'd0, slot_index}, m_slot);
        chk("final_glitch", {24'd0, glitch_count}, m_glitch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
